// File: rtl/press_arbiter.sv
// Reaction-game button arbiter: synchronizes two player buttons and decides normal/speed rounds.
// Optional input filter enabled by defining PRESS_DEBOUNCE_EN.
module press_arbiter #(
  parameter int unsigned SPEED_TARGET = 10,
  parameter int unsigned DB_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pbl,
  input  logic       pbr,
  input  logic [1:0] mode,
  input  logic       speed,
  output logic       winrnd,
  output logic       winspeed,
  output logic       leftadv,
  output logic       rightadv,
  output logic       tie,
  output logic       prio,
  output logic [3:0] cnt_l,
  output logic [3:0] cnt_r
);

  typedef enum logic [1:0] {IDLE, ARMED, SPEED, HOLD} state_t;
  typedef enum logic [1:0] {M_IDLE, M_DARK, M_PLAY, M_FAKE} mode_t;

  state_t     state, state_n;
  logic [1:0] s1, s2, lvl, prev, seen_low, vld, press;

  // seen_low only arms once real samples show the button released, so a
  // button held across reset release never yields a press event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      prev     <= '0;
      seen_low <= '0;
      vld      <= '0;
    end else begin
      s1       <= {pbr, pbl};
      s2       <= s1;
      prev     <= lvl;
      vld      <= {vld[0], 1'b1};
      seen_low <= seen_low | ({2{vld[1]}} & ~s2);
    end
  end

`ifdef PRESS_DEBOUNCE_EN
  logic [1:0] filt;
  logic [3:0] db_cnt [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (s2[i] != filt[i]) begin
          if (db_cnt[i] == 4'(DB_CYCLES - 1)) begin
            filt[i]   <= s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 4'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  assign press = lvl & ~prev & seen_low;

  logic       wr_n, ws_n, la_n, ra_n, tie_n, prio_n;
  logic [3:0] cl_n, cr_n, nl, nr;
  logic       hit_l, hit_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      winrnd   <= 1'b0;
      winspeed <= 1'b0;
      leftadv  <= 1'b0;
      rightadv <= 1'b0;
      tie      <= 1'b0;
      prio     <= 1'b0;
      cnt_l    <= '0;
      cnt_r    <= '0;
    end else begin
      state    <= state_n;
      winrnd   <= wr_n;
      winspeed <= ws_n;
      leftadv  <= la_n;
      rightadv <= ra_n;
      tie      <= tie_n;
      prio     <= prio_n;
      cnt_l    <= cl_n;
      cnt_r    <= cr_n;
    end
  end

  always_comb begin
    state_n = state;
    wr_n    = 1'b0;
    ws_n    = 1'b0;
    la_n    = 1'b0;
    ra_n    = 1'b0;
    tie_n   = 1'b0;
    prio_n  = prio;
    cl_n    = cnt_l;
    cr_n    = cnt_r;
    nl      = (press[0] && cnt_l != 4'hF) ? cnt_l + 4'd1 : cnt_l;
    nr      = (press[1] && cnt_r != 4'hF) ? cnt_r + 4'd1 : cnt_r;
    hit_l   = nl >= 4'(SPEED_TARGET);
    hit_r   = nr >= 4'(SPEED_TARGET);
    case (state)
      IDLE: begin
        if (speed) begin
          state_n = SPEED;
          cl_n    = '0;
          cr_n    = '0;
        end else if (mode != M_IDLE && lvl == 2'b00) begin
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (speed) begin
          state_n = SPEED;
          cl_n    = '0;
          cr_n    = '0;
        end else if (mode == M_IDLE) begin
          state_n = IDLE;
        end else if (press != 2'b00) begin
          state_n = HOLD;
          wr_n    = 1'b1;
          if (press == 2'b11) begin
            if (mode == M_PLAY) begin
              la_n   = ~prio;
              ra_n   = prio;
              prio_n = ~prio;
            end else begin
              tie_n = 1'b1;
            end
          end else begin
            // in dark/fake the presser is penalized: the opponent advances
            la_n = press[0] ~^ (mode == M_PLAY);
            ra_n = press[1] ~^ (mode == M_PLAY);
          end
        end
      end
      SPEED: begin
        if (!speed) begin
          state_n = IDLE;
          cl_n    = '0;
          cr_n    = '0;
        end else begin
          cl_n = nl;
          cr_n = nr;
          if (hit_l || hit_r) begin
            state_n = HOLD;
            ws_n    = 1'b1;
            if (hit_l && hit_r) begin
              la_n   = ~prio;
              ra_n   = prio;
              prio_n = ~prio;
            end else begin
              la_n = hit_l;
              ra_n = hit_r;
            end
          end
        end
      end
      HOLD: begin
        if (mode == M_IDLE && !speed) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_press_arbiter.sv
// Directed bench for press_arbiter: normal, dark/fake, tie, speed and reset scenarios.
module tb_press_arbiter;

  logic       clk = 1'b0;
  logic       rst, pbl, pbr, speed;
  logic [1:0] mode;
  logic       winrnd, winspeed, leftadv, rightadv, tie, prio;
  logic [3:0] cnt_l, cnt_r;

  int total = 0;
  int bad   = 0;
  int n_wr, n_ws, n_la, n_ra, n_tie, n_both, first;

`ifdef PRESS_DEBOUNCE_EN
  localparam int LAT = 6;
  localparam int PL  = 6;
  localparam int PW  = 5;
`else
  localparam int LAT = 2;
  localparam int PL  = 3;
  localparam int PW  = 1;
`endif
  localparam int SETTLE = PL + 4;

  press_arbiter #(.SPEED_TARGET(10), .DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .mode(mode), .speed(speed),
    .winrnd(winrnd), .winspeed(winspeed), .leftadv(leftadv), .rightadv(rightadv),
    .tie(tie), .prio(prio), .cnt_l(cnt_l), .cnt_r(cnt_r)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Buttons high for the first pl_len / pr_len sampling edges; tallies output pulses.
  task automatic watch(input int n, input int pl_len, input int pr_len);
    n_wr = 0; n_ws = 0; n_la = 0; n_ra = 0; n_tie = 0; n_both = 0; first = -1;
    pbl = (pl_len > 0);
    pbr = (pr_len > 0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if ((winrnd | winspeed | leftadv | rightadv | tie) && first < 0) first = i;
      n_wr   += int'(winrnd);
      n_ws   += int'(winspeed);
      n_la   += int'(leftadv);
      n_ra   += int'(rightadv);
      n_tie  += int'(tie);
      n_both += int'(leftadv & rightadv);
      pbl = (i + 1 < pl_len);
      pbr = (i + 1 < pr_len);
    end
  endtask

  task automatic test_reset;
    total++;
    if ({winrnd, winspeed, leftadv, rightadv, tie} !== 5'b0) begin
      bad++; $display("FAIL reset_pulses got=%b exp=00000", {winrnd, winspeed, leftadv, rightadv, tie});
    end
    total++;
    if (prio !== 1'b0) begin bad++; $display("FAIL reset_prio got=%b exp=0", prio); end
    total++;
    if ({cnt_l, cnt_r} !== 8'h00) begin bad++; $display("FAIL reset_cnt got=%h exp=00", {cnt_l, cnt_r}); end
  endtask

  task automatic test_play_single;
    mode = 2'b10; step(2);
    watch(10, 5, 0);
    total++; if (n_wr !== 1) begin bad++; $display("FAIL play_winrnd got=%0d exp=1", n_wr); end
    total++; if (n_la !== 1) begin bad++; $display("FAIL play_leftadv got=%0d exp=1", n_la); end
    total++; if (n_ra !== 0) begin bad++; $display("FAIL play_rightadv got=%0d exp=0", n_ra); end
    total++; if (first !== LAT) begin bad++; $display("FAIL play_latency got=%0d exp=%0d", first, LAT); end
    total++; if (prio !== 1'b0) begin bad++; $display("FAIL play_prio got=%b exp=0", prio); end
    watch(10, 0, PL);
    total++;
    if (n_wr + n_ws + n_la + n_ra + n_tie !== 0) begin
      bad++; $display("FAIL hold_ignores got=%0d exp=0", n_wr + n_ws + n_la + n_ra + n_tie);
    end
    mode = 2'b00; step(2);
  endtask

  task automatic test_dark_fake;
    mode = 2'b11; step(2);
    watch(10, 0, PL);
    total++; if (n_wr !== 1) begin bad++; $display("FAIL fake_winrnd got=%0d exp=1", n_wr); end
    total++; if (n_la !== 1 || n_ra !== 0) begin bad++; $display("FAIL fake_adv got=l%0d,r%0d exp=l1,r0", n_la, n_ra); end
    mode = 2'b00; step(2);
    mode = 2'b01; step(2);
    watch(10, PL, 0);
    total++; if (n_wr !== 1) begin bad++; $display("FAIL dark_winrnd got=%0d exp=1", n_wr); end
    total++; if (n_ra !== 1 || n_la !== 0) begin bad++; $display("FAIL dark_adv got=l%0d,r%0d exp=l0,r1", n_la, n_ra); end
    mode = 2'b00; step(2);
    mode = 2'b11; step(2);
    watch(10, PL, PL);
    total++; if (n_wr !== 1 || n_tie !== 1) begin bad++; $display("FAIL fake_tie got=w%0d,t%0d exp=w1,t1", n_wr, n_tie); end
    total++; if (n_la + n_ra !== 0) begin bad++; $display("FAIL fake_tie_adv got=%0d exp=0", n_la + n_ra); end
    total++; if (prio !== 1'b0) begin bad++; $display("FAIL fake_tie_prio got=%b exp=0", prio); end
    mode = 2'b00; step(2);
  endtask

  task automatic test_tie_play;
    mode = 2'b10; step(2);
    watch(10, PL, PL);
    total++; if (n_la !== 1 || n_ra !== 0) begin bad++; $display("FAIL tie1_adv got=l%0d,r%0d exp=l1,r0", n_la, n_ra); end
    total++; if (prio !== 1'b1) begin bad++; $display("FAIL tie1_prio got=%b exp=1", prio); end
    mode = 2'b00; step(2);
    mode = 2'b10; step(2);
    watch(10, PL, PL);
    total++; if (n_ra !== 1 || n_la !== 0) begin bad++; $display("FAIL tie2_adv got=l%0d,r%0d exp=l0,r1", n_la, n_ra); end
    total++; if (prio !== 1'b0) begin bad++; $display("FAIL tie2_prio got=%b exp=0", prio); end
    total++; if (n_both !== 0) begin bad++; $display("FAIL tie_both_adv got=%0d exp=0", n_both); end
    mode = 2'b00; step(2);
  endtask

  task automatic test_speed;
    mode = 2'b00; speed = 1'b1; step(2);
    n_wr = 0; n_ws = 0; n_la = 0; n_ra = 0;
    for (int i = 0; i < 20 * PW + LAT + 10; i++) begin
      pbr = ((i / PW) % 2 == 0) && (i / (2 * PW) < 10);
      pbl = ((i / PW) % 2 == 0) && (i / (2 * PW) < 7);
      @(posedge clk);
      #1;
      n_wr += int'(winrnd);
      n_ws += int'(winspeed);
      n_la += int'(leftadv);
      n_ra += int'(rightadv);
    end
    pbl = 1'b0; pbr = 1'b0;
    total++; if (n_ws !== 1 || n_wr !== 0) begin bad++; $display("FAIL speed_win got=s%0d,w%0d exp=s1,w0", n_ws, n_wr); end
    total++; if (n_ra !== 1 || n_la !== 0) begin bad++; $display("FAIL speed_adv got=l%0d,r%0d exp=l0,r1", n_la, n_ra); end
    step(5);
    total++; if (cnt_r !== 4'd10) begin bad++; $display("FAIL speed_cnt_r got=%0d exp=10", cnt_r); end
    total++; if (cnt_l !== 4'd7) begin bad++; $display("FAIL speed_cnt_l got=%0d exp=7", cnt_l); end
    speed = 1'b0; step(2);
    speed = 1'b1; step(2);
    total++; if ({cnt_l, cnt_r} !== 8'h00) begin bad++; $display("FAIL speed_entry_clear got=%h exp=00", {cnt_l, cnt_r}); end
    speed = 1'b0; step(2);
  endtask

  task automatic test_reset_mid;
    mode = 2'b10; step(2);
    watch(10, PL, PL);
    total++; if (prio !== 1'b1) begin bad++; $display("FAIL rst_pre_prio got=%b exp=1", prio); end
    mode = 2'b00; step(2);
    mode = 2'b10; step(2);
    rst = 1'b1; pbl = 1'b1;
    #1;
    total++; if (prio !== 1'b0) begin bad++; $display("FAIL rst_async_prio got=%b exp=0", prio); end
    step(2);
    rst = 1'b0;
    watch(12, 12, 0);
    total++;
    if (n_wr + n_ws + n_la + n_ra + n_tie !== 0) begin
      bad++; $display("FAIL rst_held_button got=%0d exp=0", n_wr + n_ws + n_la + n_ra + n_tie);
    end
    step(SETTLE);
    watch(12, PL, 0);
    total++; if (n_wr !== 1 || n_la !== 1) begin bad++; $display("FAIL rst_repress got=w%0d,l%0d exp=w1,l1", n_wr, n_la); end
    total++; if (first !== LAT) begin bad++; $display("FAIL rst_repress_latency got=%0d exp=%0d", first, LAT); end
    mode = 2'b00; step(2);
  endtask

`ifdef PRESS_DEBOUNCE_EN
  task automatic test_debounce;
    mode = 2'b10; step(2);
    watch(12, 2, 0);
    total++; if (n_wr !== 0) begin bad++; $display("FAIL db_glitch got=%0d exp=0", n_wr); end
    step(SETTLE);
    watch(16, 6, 0);
    total++; if (n_wr !== 1) begin bad++; $display("FAIL db_press got=%0d exp=1", n_wr); end
    total++; if (first !== 6) begin bad++; $display("FAIL db_latency got=%0d exp=6", first); end
    mode = 2'b00; step(2);
  endtask
`else
  task automatic test_short_press;
    mode = 2'b10; step(2);
    watch(8, 1, 0);
    total++; if (n_wr !== 1) begin bad++; $display("FAIL short_press got=%0d exp=1", n_wr); end
    total++; if (first !== 2) begin bad++; $display("FAIL short_latency got=%0d exp=2", first); end
    mode = 2'b00; step(2);
  endtask
`endif

  initial begin
    rst = 1'b1; pbl = 1'b0; pbr = 1'b0; speed = 1'b0; mode = 2'b00;
    step(2);
    test_reset;
    rst = 1'b0;
    step(4);
    test_play_single;
    test_dark_fake;
    test_tie_play;
    test_speed;
    test_reset_mid;
`ifdef PRESS_DEBOUNCE_EN
    test_debounce;
`else
    test_short_press;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
